note_fetch_scheduler: RTL
=========================

// Module: note_fetch_scheduler
// PURPOSE
//  Sequences one shared song_rom port for the note-display path. On a new
//  current_addr it fetches the five display slots (prev2, prev1, curr, next1, next2)
//  serially, pipelined, into a shadow bank, then commits all five atomically.
//  The commit happens at a frame boundary, so the glyph lookup never sees a mixed set.
//  One song_rom serves all slots.
// PARAMETERS
//  ADDR_W       6   song ROM address width; all slot addresses wrap mod 2**ADDR_W
//  DATA_W       16  song ROM word width; the note field is dout[14:9]
//  ROM_LAT      1   cycles from rom_addr presented to matching rom_dout valid (1..3)
//  SYNC_COMMIT  1   1: hold shadow until frame_start; 0: commit right after fetch
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  current_addr   in   ADDR_W  song position from the player
//  frame_start    in   1       one-cycle pulse at start of each video frame
//  rom_addr       out  ADDR_W  registered address to shared song_rom
//  rom_dout       in   DATA_W  song_rom data, valid ROM_LAT cycles after rom_addr
//  note_p2/p1     out  6       committed notes at current_addr-3 / current_addr-2
//  note_curr      out  6       committed note at current_addr
//  note_n1/n2     out  6       committed notes at current_addr+1 / current_addr+2
//  notes_valid    out  1       high after the first commit since reset
//  notes_updated  out  1       one-cycle pulse in the commit cycle
//  busy           out  1       high in FETCH and WAIT_FRAME
// BEHAVIOUR
//  Reset (async assert): all outputs 0; FSM=IDLE; shadow cleared; pending=1 (forces first fetch).
//  Reset mid-operation aborts the fetch and discards the shadow.
//  pending is set when current_addr != base (the last latched address), checked every cycle.
//  pending is cleared when the FSM latches base.
//  FSM:
//   IDLE: if pending, set base<=current_addr and go to FETCH. Otherwise stay; rom_addr holds.
//   FETCH: runs 5+ROM_LAT cycles, with slot counter k=0..4.
//    In cycle k, rom_addr is registered to base-3, base-2, base, base+1, base+2 in order.
//    The result is ADDR_W-bit modular; base-1 (the duration word) is never fetched.
//    rom_dout[14:9] for slot k is captured into shadow[k] ROM_LAT cycles after rom_addr=slot k.
//    This uses a ROM_LAT-deep valid/index delay line.
//    After the last capture: WAIT_FRAME if SYNC_COMMIT, else COMMIT.
//   WAIT_FRAME: on frame_start go to COMMIT. Outputs keep their old values meanwhile.
//   COMMIT: takes 1 cycle. Copy all five shadows to outputs in the same edge.
//    Pulse notes_updated and set notes_valid=1, then go to IDLE.
//    If pending is set, the next fetch starts the following cycle.
//  Simultaneous and boundary events:
//   current_addr changes during FETCH/WAIT_FRAME: the fetch in flight completes with the old base.
//    pending causes exactly one refetch with the newest address. Intermediate values are skipped.
//   frame_start during FETCH/IDLE: ignored; it does not arm the commit.
//   frame_start in the same cycle FSM enters WAIT_FRAME: not seen; the next pulse commits.
//   Address wrap: base=1 gives p2=62, p1=63; base=63 gives n1=0, n2=1.
//  Latency (SYNC_COMMIT=0): change -> notes_updated = 1 (IDLE) + 5+ROM_LAT + 1 cycles.
//  Outputs change only in COMMIT. rom_addr changes only in FETCH.
// TESTING
//  ROM model: dout[14:9]=addr, other bits random, latency ROM_LAT.
//  1. Reset, current_addr=10, SYNC_COMMIT=0 -> rom_addr 7,8,10,11,12 on consecutive cycles.
//     Then p2=7, p1=8, curr=10, n1=11, n2=12, one notes_updated pulse, notes_valid=1.
//  2. current_addr=1, then 63 -> commits {62,63,1,2,3}, then {60,61,63,0,1}.
//  3. addr 10->20->30 during FETCH cycles 1 and 3 -> exactly two commits, {7..12} then {27..32}.
//  4. SYNC_COMMIT=1, frame_start withheld 100 cycles -> outputs hold, busy=1.
//     Pulse frame_start -> commit next cycle.
//  5. ROM_LAT=3, current_addr=40 -> {37,38,40,41,42}; FETCH lasts 8 cycles.
//  6. rst_n low during FETCH cycle 2 -> all outputs 0 at once.
//     After release, a fresh fetch of current_addr with correct notes.

Source files
------------

// File: rtl/note_fetch_scheduler.sv
// Sequences one shared song_rom port to fetch the five display-slot notes into a
// shadow bank, then commits the whole set atomically (optionally on a frame boundary).
module note_fetch_scheduler #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int ROM_LAT     = 1,
    parameter bit SYNC_COMMIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] current_addr,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [5:0]        note_p2,
    output logic [5:0]        note_p1,
    output logic [5:0]        note_curr,
    output logic [5:0]        note_n1,
    output logic [5:0]        note_n2,
    output logic              notes_valid,
    output logic              notes_updated,
    output logic              busy
);

    localparam int         NSLOT      = 5;
    localparam logic [3:0] FETCH_LAST = 4'(NSLOT - 1 + ROM_LAT);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_FRAME, COMMIT} state_t;

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  base;
    logic               pending;
    logic               fetch_req;
    logic [3:0]         fetch_cnt;
    logic               latch_en;
    logic               issue_en;
    logic               commit_en;
    logic [ROM_LAT-1:0] vld_p;
    logic [2:0]         idx_p [ROM_LAT];
    logic [5:0]         shadow [NSLOT];
    logic               unused_rom_bits;

    // Slot order is prev2, prev1, curr, next1, next2; base-1 holds the duration word.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [2:0]        k);
        case (k)
            3'd0:    slot_addr = b - ADDR_W'(3);
            3'd1:    slot_addr = b - ADDR_W'(2);
            3'd2:    slot_addr = b;
            3'd3:    slot_addr = b + ADDR_W'(1);
            default: slot_addr = b + ADDR_W'(2);
        endcase
    endfunction

    function automatic logic [5:0] note_field(input logic [DATA_W-1:0] d);
        note_field = d[14:9];
    endfunction

    assign fetch_req       = pending || (current_addr != base);
    assign unused_rom_bits = ^rom_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (fetch_req) state_nx = FETCH;
            FETCH:      if (fetch_cnt == FETCH_LAST) state_nx = SYNC_COMMIT ? WAIT_FRAME : COMMIT;
            WAIT_FRAME: if (frame_start) state_nx = COMMIT;
            COMMIT:     state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        latch_en  = 1'b0;
        issue_en  = 1'b0;
        commit_en = 1'b0;
        case (state)
            IDLE:       latch_en = fetch_req;
            FETCH: begin
                busy     = 1'b1;
                issue_en = (fetch_cnt < 4'(NSLOT));
            end
            WAIT_FRAME: busy = 1'b1;
            COMMIT:     commit_en = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // Change tracking: a latch consumes the request; any later mismatch re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b1;
            base      <= '0;
            fetch_cnt <= '0;
        end else begin
            if (latch_en) begin
                pending <= 1'b0;
                base    <= current_addr;
            end else if (current_addr != base) begin
                pending <= 1'b1;
            end
            if (latch_en) begin
                fetch_cnt <= '0;
            end else if (state == FETCH) begin
                fetch_cnt <= fetch_cnt + 4'd1;
            end
        end
    end

    // Issue stage p0: address register plus slot tag that tracks the ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            vld_p    <= '0;
            for (int i = 0; i < ROM_LAT; i++) idx_p[i] <= '0;
        end else begin
            if (issue_en) rom_addr <= slot_addr(base, fetch_cnt[2:0]);
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
            vld_p[0] <= issue_en;
            idx_p[0] <= fetch_cnt[2:0];
        end
    end

    // Capture stage: tag reaches the tail exactly when rom_dout holds that slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) shadow[i] <= '0;
        end else if (vld_p[ROM_LAT-1]) begin
            shadow[idx_p[ROM_LAT-1]] <= note_field(rom_dout);
        end
    end

    // Commit stage: all five visible notes move together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_p2       <= '0;
            note_p1       <= '0;
            note_curr     <= '0;
            note_n1       <= '0;
            note_n2       <= '0;
            notes_valid   <= 1'b0;
            notes_updated <= 1'b0;
        end else begin
            if (commit_en) begin
                note_p2   <= shadow[0];
                note_p1   <= shadow[1];
                note_curr <= shadow[2];
                note_n1   <= shadow[3];
                note_n2   <= shadow[4];
            end
            notes_updated <= commit_en;
            notes_valid   <= notes_valid | commit_en;
        end
    end

endmodule
